// File: rtl/vga_pkg.sv
// Shared timing defaults and types for the VGA raster scan generator.
// Totals are derived from the four per-axis timing parameters.
package vga_pkg;

    localparam int unsigned H_VISIBLE_DEF  = 32'd640;
    localparam int unsigned H_FP_DEF       = 32'd16;
    localparam int unsigned H_SYNC_DEF     = 32'd96;
    localparam int unsigned H_BP_DEF       = 32'd48;
    localparam int unsigned V_VISIBLE_DEF  = 32'd480;
    localparam int unsigned V_FP_DEF       = 32'd10;
    localparam int unsigned V_SYNC_DEF     = 32'd2;
    localparam int unsigned V_BP_DEF       = 32'd33;
    localparam int unsigned PIPE_DELAY_DEF = 32'd1;

    localparam int unsigned CNT_W = 32'd10;

    typedef logic [CNT_W-1:0] vga_cnt_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } vga_sync_t;

    // Inactive syncs and blanked video: the state every delay stage resets to.
    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    function automatic int unsigned vga_total(
        input int unsigned visible,
        input int unsigned fp,
        input int unsigned sync,
        input int unsigned bp
    );
        return visible + fp + sync + bp;
    endfunction

    localparam int unsigned H_TOTAL_DEF = vga_total(H_VISIBLE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
    localparam int unsigned V_TOTAL_DEF = vga_total(V_VISIBLE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-generator output bundle: pixel coordinates plus the VGA DAC controls.
// The generator drives the master side; the colour mapper / DAC take the slave side.
interface vga_scan_gen_if;
    import vga_pkg::*;

    vga_cnt_t DrawX;
    vga_cnt_t DrawY;
    logic     pixel_tick;
    logic     VGA_CLK;
    logic     VGA_HS;
    logic     VGA_VS;
    logic     VGA_BLANK_N;
    logic     VGA_SYNC_N;
    logic     frame_clk;
    logic     frame_start;

    modport master (
        output DrawX,
        output DrawY,
        output pixel_tick,
        output VGA_CLK,
        output VGA_HS,
        output VGA_VS,
        output VGA_BLANK_N,
        output VGA_SYNC_N,
        output frame_clk,
        output frame_start
    );

    modport slave (
        input DrawX,
        input DrawY,
        input pixel_tick,
        input VGA_CLK,
        input VGA_HS,
        input VGA_VS,
        input VGA_BLANK_N,
        input VGA_SYNC_N,
        input frame_clk,
        input frame_start
    );

endinterface

// File: rtl/sync_delay_line.sv
// Enable-gated shift register that re-aligns sync/blank with the colour path.
// DEPTH = 0 is a pure pass-through.
module sync_delay_line
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH   = PIPE_DELAY_DEF,
    parameter type         T       = vga_sync_t,
    parameter T            RST_VAL = SYNC_IDLE
) (
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    input  T     d,
    output T     q
);

    if (DEPTH == 32'd0) begin : g_bypass

        logic unused_s;
        assign unused_s = &{1'b0, Clk, Reset, en};
        assign q        = d;

    end else begin : g_pipe

        T stage_r [DEPTH];

        // Shift one stage per pixel; reset parks every stage at the idle value.
        always_ff @(posedge Clk) begin
            if (Reset) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    stage_r[i] <= RST_VAL;
                end
            end else if (en) begin
                stage_r[0] <= d;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage_r[i] <= stage_r[i-1];
                end
            end
        end

        assign q = stage_r[DEPTH-1];

    end

endmodule

// File: rtl/vga_scan_gen_chk.sv
// Run-time invariants of the scan generator outputs (simulation only).
module vga_scan_gen_chk
    import vga_pkg::*;
#(
    parameter vga_cnt_t H_LAST = 10'd799,
    parameter vga_cnt_t V_LAST = 10'd524
) (
    input logic     Clk,
    input logic     Reset,
    input vga_cnt_t DrawX,
    input vga_cnt_t DrawY,
    input logic     frame_start,
    input logic     VGA_SYNC_N
);

    a_x_in_range: assert property (@(posedge Clk) disable iff (Reset) (DrawX <= H_LAST));

    a_y_in_range: assert property (@(posedge Clk) disable iff (Reset) (DrawY <= V_LAST));

    a_frame_start_at_origin: assert property (@(posedge Clk) disable iff (Reset)
        (frame_start |-> ((DrawX == 10'd0) && (DrawY == 10'd0))));

    a_sync_n_tied: assert property (@(posedge Clk) (VGA_SYNC_N == 1'b0));

endmodule

// File: rtl/vga_scan_gen.sv
// 640x480@60 raster scan generator: 25 MHz pixel cadence from a 50 MHz clock,
// pixel coordinates, and sync/blank delayed to match the sprite-ROM latency.
module vga_scan_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned PIPE_DELAY = PIPE_DELAY_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    vga_scan_gen_if.master        vga
);

    localparam int unsigned H_TOTAL = vga_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = vga_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

    localparam vga_cnt_t H_LAST   = CNT_W'(H_TOTAL - 32'd1);
    localparam vga_cnt_t V_LAST   = CNT_W'(V_TOTAL - 32'd1);
    localparam vga_cnt_t H_VIS    = CNT_W'(H_VISIBLE);
    localparam vga_cnt_t V_VIS    = CNT_W'(V_VISIBLE);
    localparam vga_cnt_t HS_FIRST = CNT_W'(H_VISIBLE + H_FP);
    localparam vga_cnt_t HS_LAST  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 32'd1);
    localparam vga_cnt_t VS_FIRST = CNT_W'(V_VISIBLE + V_FP);
    localparam vga_cnt_t VS_LAST  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 32'd1);

    logic      tick_r;
    vga_cnt_t  hc_r;
    vga_cnt_t  vc_r;
    logic      frame_start_r;
    logic      h_wrap_s;
    logic      v_wrap_s;
    vga_sync_t raw_sync_s;
    vga_sync_t dly_sync_s;

    // Divide-by-two pixel cadence; the tick is high every other Clk.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= ~tick_r;
        end
    end

    // End-of-line and end-of-frame detection on the current counts.
    always_comb begin
        h_wrap_s = (hc_r == H_LAST);
        v_wrap_s = (vc_r == V_LAST);
    end

    // Horizontal/vertical counters; line and frame wrap happen on the same tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hc_r <= 10'd0;
            vc_r <= 10'd0;
        end else if (tick_r) begin
            if (h_wrap_s) begin
                hc_r <= 10'd0;
                vc_r <= v_wrap_s ? 10'd0 : (vc_r + 10'd1);
            end else begin
                hc_r <= hc_r + 10'd1;
            end
        end
    end

    // Flags the Clk right after the counters land on (0,0).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= tick_r & h_wrap_s & v_wrap_s;
        end
    end

    // Undelayed sync/blank decoded from the live counts.
    always_comb begin
        raw_sync_s.hs      = ~((hc_r >= HS_FIRST) && (hc_r <= HS_LAST));
        raw_sync_s.vs      = ~((vc_r >= VS_FIRST) && (vc_r <= VS_LAST));
        raw_sync_s.blank_n = (hc_r < H_VIS) && (vc_r < V_VIS);
    end

    sync_delay_line #(
        .DEPTH   (PIPE_DELAY),
        .T       (vga_sync_t),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (tick_r),
        .d     (raw_sync_s),
        .q     (dly_sync_s)
    );

    // The DAC samples on the rising VGA_CLK edge, mid-way through each pixel.
    assign vga.DrawX       = hc_r;
    assign vga.DrawY       = vc_r;
    assign vga.pixel_tick  = tick_r;
    assign vga.VGA_CLK     = ~tick_r;
    assign vga.VGA_HS      = dly_sync_s.hs;
    assign vga.VGA_VS      = dly_sync_s.vs;
    assign vga.VGA_BLANK_N = dly_sync_s.blank_n;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.frame_clk   = raw_sync_s.vs;
    assign vga.frame_start = frame_start_r;

    vga_scan_gen_chk #(
        .H_LAST (H_LAST),
        .V_LAST (V_LAST)
    ) u_chk (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (hc_r),
        .DrawY       (vc_r),
        .frame_start (frame_start_r),
        .VGA_SYNC_N  (1'b0)
    );

endmodule

// File: tb/tb_vga_scan_gen.sv
// Self-checking bench for vga_scan_gen: full-size timing on two instances and a
// shrunken-raster instance for whole-frame, mid-frame reset and corner-wrap behaviour.
module tb_vga_scan_gen;
    import vga_pkg::*;

    localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 2;
    localparam int SVV = 6, SVF = 1, SVS = 2, SVB = 2;
    localparam int SHT = SHV + SHF + SHS + SHB;
    localparam int SVT = SVV + SVF + SVS + SVB;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       pt;
        logic       vclk;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       fclk;
        logic       fs;
    } obs_t;

    logic Clk = 1'b0;
    logic Reset;
    logic rst_s;
    int   errors = 0;
    int   checks = 0;
    int   k_main = 0;
    int   k_small = 0;
    obs_t sb_q[$];
    obs_t obs_0, obs_2, obs_s;

    vga_scan_gen_if if0 ();
    vga_scan_gen_if if2 ();
    vga_scan_gen_if ifs ();

    vga_scan_gen #(.PIPE_DELAY(0)) dut0 (.Clk(Clk), .Reset(Reset), .vga(if0));
    vga_scan_gen #(.PIPE_DELAY(2)) dut2 (.Clk(Clk), .Reset(Reset), .vga(if2));
    vga_scan_gen #(
        .H_VISIBLE(SHV), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_VISIBLE(SVV), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB),
        .PIPE_DELAY(1)
    ) dut_s (.Clk(Clk), .Reset(rst_s), .vga(ifs));

    always #10 Clk = ~Clk;

    assign obs_0 = {if0.DrawX, if0.DrawY, if0.pixel_tick, if0.VGA_CLK, if0.VGA_HS,
                    if0.VGA_VS, if0.VGA_BLANK_N, if0.frame_clk, if0.frame_start};
    assign obs_2 = {if2.DrawX, if2.DrawY, if2.pixel_tick, if2.VGA_CLK, if2.VGA_HS,
                    if2.VGA_VS, if2.VGA_BLANK_N, if2.frame_clk, if2.frame_start};
    assign obs_s = {ifs.DrawX, ifs.DrawY, ifs.pixel_tick, ifs.VGA_CLK, ifs.VGA_HS,
                    ifs.VGA_VS, ifs.VGA_BLANK_N, ifs.frame_clk, ifs.frame_start};

    // Closed-form expectation after k Clk edges since reset (k = 0 means in reset):
    // pixel index p = k/2, sync/blank show pixel p-d, idle before the pipe fills.
    function automatic obs_t model(input int k, input int hv, input int hf, input int hsw,
                                   input int hb, input int vv, input int vf, input int vsw,
                                   input int vb, input int d);
        obs_t e;
        int ht, vt, p, x, y, pd, xd, yd;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = k / 2;
        x  = p % ht;
        y  = (p / ht) % vt;
        e.x    = 10'(x);
        e.y    = 10'(y);
        e.pt   = (k % 2) == 1;
        e.vclk = (k % 2) == 0;
        e.fclk = !((y >= vv + vf) && (y < vv + vf + vsw));
        e.fs   = (k > 0) && ((k % 2) == 0) && ((p % (ht * vt)) == 0);
        pd = p - d;
        if (pd < 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
            e.bn = 1'b0;
        end else begin
            xd = pd % ht;
            yd = (pd / ht) % vt;
            e.hs = !((xd >= hv + hf) && (xd < hv + hf + hsw));
            e.vs = !((yd >= vv + vf) && (yd < vv + vf + vsw));
            e.bn = (xd < hv) && (yd < vv);
        end
        return e;
    endfunction

    // One Clk: advance the edge counts, queue the small-raster expectation, settle at negedge.
    task automatic clk_step();
        @(posedge Clk);
        k_main  = Reset ? 0 : k_main + 1;
        k_small = rst_s ? 0 : k_small + 1;
        sb_q.push_back(model(k_small, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1));
        @(negedge Clk);
    endtask

    task automatic test_reset();
        obs_t e;
        sb_q.delete();
        Reset = 1'b1;
        rst_s = 1'b1;
        repeat (3) begin
            clk_step();
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++;
                $display("FAIL reset_small got=%h want=%h", obs_s, e);
            end
            checks++;
            if (obs_2 !== {20'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_state got=%h want=%h", obs_2,
                         {20'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});
            end
            checks++;
            if ({if0.DrawX, if0.DrawY, if0.VGA_HS, if0.VGA_VS} !== {20'd0, 2'b11}) begin
                errors++;
                $display("FAIL reset_nodelay got=%h want=%h",
                         {if0.DrawX, if0.DrawY, if0.VGA_HS, if0.VGA_VS}, {20'd0, 2'b11});
            end
        end
        Reset = 1'b0;
        rst_s = 1'b0;
        clk_step();
        e = sb_q.pop_front();
        checks++;
        if ((if0.DrawX !== 10'd0) || (if0.pixel_tick !== 1'b1) || (obs_s !== e)) begin
            errors++;
            $display("FAIL first_tick x=%0d pt=%b small=%h want x=0 pt=1 small=%h",
                     if0.DrawX, if0.pixel_tick, obs_s, e);
        end
        clk_step();
        e = sb_q.pop_front();
        checks++;
        if ((if0.DrawX !== 10'd1) || (obs_s !== e)) begin
            errors++;
            $display("FAIL first_incr x=%0d small=%h want x=1 small=%h", if0.DrawX, obs_s, e);
        end
    endtask

    task automatic test_line();
        obs_t e;
        int   hs_low, bn_high, first_hs_x, k_y1, k_y2;
        logic seen_hs;
        hs_low = 0; bn_high = 0; first_hs_x = -1; k_y1 = -1; k_y2 = -1; seen_hs = 1'b0;
        Reset = 1'b1;
        clk_step();
        Reset = 1'b0;
        while (k_main < 3300) begin
            clk_step();
            e = model(k_main, 640, 16, 96, 48, 480, 10, 2, 33, 0);
            checks++;
            if (obs_0 !== e) begin
                errors++;
                $display("FAIL line_cycle k=%0d got=%h want=%h", k_main, obs_0, e);
            end
            if ((k_main >= 1600) && (k_main < 3200)) begin
                if (if0.VGA_HS === 1'b0) hs_low++;
                if (if0.VGA_BLANK_N === 1'b1) bn_high++;
            end
            if ((if0.VGA_HS === 1'b0) && !seen_hs) begin
                seen_hs    = 1'b1;
                first_hs_x = int'(if0.DrawX);
            end
            if ((if0.DrawY === 10'd1) && (k_y1 < 0)) k_y1 = k_main;
            if ((if0.DrawY === 10'd2) && (k_y2 < 0)) k_y2 = k_main;
        end
        checks++;
        if (first_hs_x != 656) begin
            errors++;
            $display("FAIL hs_start_x got=%0d want=656", first_hs_x);
        end
        checks++;
        if (hs_low != 192) begin
            errors++;
            $display("FAIL hs_width_clk got=%0d want=192", hs_low);
        end
        checks++;
        if (bn_high != 1280) begin
            errors++;
            $display("FAIL blank_width_clk got=%0d want=1280", bn_high);
        end
        checks++;
        if ((k_y1 != 1600) || (k_y2 - k_y1 != 1600)) begin
            errors++;
            $display("FAIL line_period y1_at=%0d y2_at=%0d want 1600 and 3200", k_y1, k_y2);
        end
    endtask

    task automatic test_pipe_delay();
        obs_t e;
        int   k656, khs, k640, kbn;
        logic prev_bn;
        k656 = -1; khs = -1; k640 = -1; kbn = -1; prev_bn = 1'b0;
        Reset = 1'b1;
        clk_step();
        Reset = 1'b0;
        while (k_main < 1500) begin
            clk_step();
            e = model(k_main, 640, 16, 96, 48, 480, 10, 2, 33, 2);
            checks++;
            if (obs_2 !== e) begin
                errors++;
                $display("FAIL pipe_cycle k=%0d got=%h want=%h", k_main, obs_2, e);
            end
            if ((if2.DrawX === 10'd656) && (k656 < 0)) k656 = k_main;
            if ((if2.DrawX === 10'd640) && (k640 < 0)) k640 = k_main;
            if ((if2.VGA_HS === 1'b0) && (khs < 0)) khs = k_main;
            if (prev_bn && (if2.VGA_BLANK_N === 1'b0) && (kbn < 0)) kbn = k_main;
            prev_bn = (if2.VGA_BLANK_N === 1'b1);
        end
        checks++;
        if ((k656 < 0) || (khs - k656 != 4)) begin
            errors++;
            $display("FAIL hs_latency got=%0d clk (x656@%0d fall@%0d) want=4", khs - k656, k656, khs);
        end
        checks++;
        if ((k640 < 0) || (kbn - k640 != 4)) begin
            errors++;
            $display("FAIL blank_latency got=%0d clk (x640@%0d fall@%0d) want=4", kbn - k640, k640, kbn);
        end
    endtask

    task automatic test_frame();
        obs_t e;
        int   pulses, k_p1, k_p2, vs_low, k_rise;
        logic prev_fclk;
        pulses = 0; k_p1 = -1; k_p2 = -1; vs_low = 0; k_rise = -1; prev_fclk = 1'b1;
        sb_q.delete();
        rst_s = 1'b1;
        clk_step();
        void'(sb_q.pop_front());
        rst_s = 1'b0;
        repeat (700) begin
            clk_step();
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++;
                $display("FAIL frame_cycle k=%0d got=%h want=%h", k_small, obs_s, e);
            end
            if (ifs.frame_start === 1'b1) begin
                pulses++;
                if (pulses == 1) k_p1 = k_small;
                if (pulses == 2) k_p2 = k_small;
            end
            if ((k_small < 330) && (ifs.VGA_VS === 1'b0)) vs_low++;
            if (!prev_fclk && (ifs.frame_clk === 1'b1) && (k_rise < 0)) k_rise = k_small;
            prev_fclk = (ifs.frame_clk === 1'b1);
        end
        checks++;
        if ((pulses != 2) || (k_p1 != 330) || (k_p2 != 660)) begin
            errors++;
            $display("FAIL frame_start_cadence got n=%0d at %0d,%0d want n=2 at 330,660", pulses, k_p1, k_p2);
        end
        checks++;
        if (vs_low != 60) begin
            errors++;
            $display("FAIL vs_width_clk got=%0d want=60", vs_low);
        end
        checks++;
        if (k_rise != 270) begin
            errors++;
            $display("FAIL frame_clk_rise got=%0d want=270", k_rise);
        end
    endtask

    task automatic test_midframe_reset();
        obs_t e;
        int   hs_low_early;
        hs_low_early = 0;
        sb_q.delete();
        rst_s = 1'b1;
        clk_step();
        void'(sb_q.pop_front());
        rst_s = 1'b0;
        while (k_small < 112) begin
            clk_step();
            void'(sb_q.pop_front());
        end
        checks++;
        if ((ifs.DrawX !== 10'd11) || (ifs.DrawY !== 10'd3) || (ifs.VGA_HS !== 1'b0)) begin
            errors++;
            $display("FAIL pre_reset_pos got x=%0d y=%0d hs=%b want x=11 y=3 hs=0",
                     ifs.DrawX, ifs.DrawY, ifs.VGA_HS);
        end
        rst_s = 1'b1;
        clk_step();
        e = sb_q.pop_front();
        checks++;
        if (obs_s !== e) begin
            errors++;
            $display("FAIL midframe_reset_state got=%h want=%h", obs_s, e);
        end
        rst_s = 1'b0;
        repeat (40) begin
            clk_step();
            e = sb_q.pop_front();
            checks++;
            if (obs_s !== e) begin
                errors++;
                $display("FAIL restart_cycle k=%0d got=%h want=%h", k_small, obs_s, e);
            end
            if ((k_small <= 20) && (ifs.VGA_HS !== 1'b1)) hs_low_early++;
        end
        checks++;
        if (hs_low_early != 0) begin
            errors++;
            $display("FAIL stale_hsync got=%0d low cycles want=0", hs_low_early);
        end
    endtask

    task automatic test_corner_wrap();
        obs_t e;
        sb_q.delete();
        rst_s = 1'b1;
        clk_step();
        void'(sb_q.pop_front());
        rst_s = 1'b0;
        repeat (340) begin
            clk_step();
            e = sb_q.pop_front();
            checks++;
            if ((obs_s !== e) || (ifs.DrawX >= 10'(SHT)) || (ifs.DrawY >= 10'(SVT))) begin
                errors++;
                $display("FAIL wrap_cycle k=%0d got=%h want=%h", k_small, obs_s, e);
            end
            if (k_small == 328) begin
                checks++;
                if ((ifs.DrawX !== 10'd14) || (ifs.DrawY !== 10'd10)) begin
                    errors++;
                    $display("FAIL corner_pos got x=%0d y=%0d want x=14 y=10", ifs.DrawX, ifs.DrawY);
                end
            end
            if (k_small == 330) begin
                checks++;
                if ((ifs.DrawX !== 10'd0) || (ifs.DrawY !== 10'd0) || (ifs.frame_start !== 1'b1)) begin
                    errors++;
                    $display("FAIL corner_wrap got x=%0d y=%0d fs=%b want x=0 y=0 fs=1",
                             ifs.DrawX, ifs.DrawY, ifs.frame_start);
                end
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        rst_s = 1'b1;
        test_reset();
        test_line();
        test_pipe_delay();
        test_frame();
        test_midframe_reset();
        test_corner_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
